// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div -- multi-cycle restoring integer divider (one quotient bit per clock)
//
// Computes quotient and remainder for signed or unsigned WIDTH-bit operands.
// Division by zero and signed overflow (minimum value / -1) are resolved at
// accept time. They go straight to DONE with RISC-V M-extension results.
// All other operands take the full CALC/FIX path.
//
// Ports:
//   clk          in   clock, all registers update on the rising edge
//   rst_n        in   synchronous active-low reset
//   in_valid     in   operands valid
//   in_ready     out  divider idle, operands will be accepted
//   dividend     in   WIDTH-bit dividend (signed or unsigned per is_signed)
//   divisor      in   WIDTH-bit divisor  (signed or unsigned per is_signed)
//   is_signed    in   1 = signed division, 0 = unsigned
//   out_valid    out  result valid
//   out_ready    in   consumer accepts the result
//   quotient     out  quotient, truncated toward zero
//   remainder    out  remainder, sign follows the dividend
//   div_by_zero  out  divisor was zero
//   overflow     out  signed minimum value divided by -1
// -----------------------------------------------------------------------------
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder (magnitude)
  logic [WIDTH-1:0]   quo_q, quo_d;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // |divisor|
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [WIDTH-1:0]   quot_out_q, quot_out_d;
  logic [WIDTH-1:0]   rem_out_q, rem_out_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Operand decode at accept time
  // ---------------------------------------------------------------------------
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             is_zero_div, is_signed_ovf;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // The magnitude of the most negative value is 2^(WIDTH-1). That value still
  // fits as an unsigned WIDTH-bit number, so no extra bit is needed.
  assign dvd_abs = dvd_neg ? (~dividend) + WIDTH'(1) : dividend;
  assign dvs_abs = dvs_neg ? (~divisor)  + WIDTH'(1) : divisor;

  assign is_zero_div   = (divisor == '0);
  assign is_signed_ovf = is_signed
                         && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         && (divisor == '1);

  // ---------------------------------------------------------------------------
  // One restoring iteration
  // ---------------------------------------------------------------------------
  // Shift {rem, quo} left by one and trial-subtract |divisor| at WIDTH+1 bits.
  // Because rem < |divisor| on entry, the shifted value is below 2*|divisor|.
  // The top bit of the difference is therefore exactly the borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign borrow  = diff[WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one
    // unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_zero_div) begin
            quot_out_d = '1;
            rem_out_d  = dividend;
            dbz_d      = 1'b1;
            ovf_d      = 1'b0;
            state_d    = S_DONE;
          end else if (is_signed_ovf) begin
            quot_out_d = dividend;
            rem_out_d  = '0;
            dbz_d      = 1'b0;
            ovf_d      = 1'b1;
            state_d    = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dvd_abs;
            dvs_d   = dvs_abs;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        // On a borrow the shifted remainder is restored. It is below |divisor|,
        // so its low WIDTH bits are its full value.
        rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        quot_out_d = q_neg_q ? (~quo_q) + WIDTH'(1) : quo_q;
        rem_out_d  = r_neg_q ? (~rem_q) + WIDTH'(1) : rem_q;
        dbz_d      = 1'b0;
        ovf_d      = 1'b0;
        state_d    = S_DONE;
      end

      S_DONE: begin
        // Results stay in their registers until the handshake and afterwards.
        // This state deliberately does not accept new operands.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from registers, never from inputs
  // ---------------------------------------------------------------------------
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div -- directed, table-driven bench for seq_div (WIDTH = 32)
// -----------------------------------------------------------------------------
module tb_seq_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after an accept edge. Returns the cycle count (T+k) at which
  // out_valid is first seen. A count of 100 means it never came.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  // Present operands, wait (bounded) for the accept edge, then scramble the
  // inputs so that capture is exercised.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int guard;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~s;
  endtask

  initial begin
    int           lat;
    logic [W-1:0] hq, hr;
    logic         hdbz, hovf;
    logic         stable;

    vecs[0]  = '{"u 100/7",        32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0, 34};
    vecs[1]  = '{"s -7/2",         32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    vecs[2]  = '{"s 7/-2",         32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 34};
    vecs[3]  = '{"u 5/0",          32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1};
    vecs[4]  = '{"s 5/0",          32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1};
    vecs[5]  = '{"s min/-1",       32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1, 1};
    vecs[6]  = '{"u 80000000/max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0, 34};
    vecs[7]  = '{"s -100/-7",      32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 34};
    vecs[8]  = '{"u max/1",        32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 34};
    vecs[9]  = '{"s min/2",        32'h80000000, 32'd2,        1'b1, 32'hC0000000, 32'd0,        1'b0, 1'b0, 34};
    vecs[10] = '{"u 3/10",         32'd3,        32'd10,       1'b0, 32'd0,        32'd3,        1'b0, 1'b0, 34};
    vecs[11] = '{"s -5/0",         32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 1};
    vecs[12] = '{"u max/16",       32'hFFFFFFFF, 32'h10,       1'b0, 32'h0FFFFFFF, 32'hF,        1'b0, 1'b0, 34};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst in_ready",    32'(in_ready),    32'd1);
    check("rst out_valid",   32'(out_valid),   32'd0);
    check("rst quotient",    quotient,         32'd0);
    check("rst remainder",   remainder,        32'd0);
    check("rst div_by_zero", 32'(div_by_zero), 32'd0);
    check("rst overflow",    32'(overflow),    32'd0);

    // Table-driven vectors, out_ready held high
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_result(lat);
      check({vecs[i].name, " latency"},   32'(lat),         32'(vecs[i].lat));
      check({vecs[i].name, " quotient"},  quotient,         vecs[i].q);
      check({vecs[i].name, " remainder"}, remainder,        vecs[i].r);
      check({vecs[i].name, " dbz"},       32'(div_by_zero), 32'(vecs[i].dbz));
      check({vecs[i].name, " ovf"},       32'(overflow),    32'(vecs[i].ovf));
    end

    // Back-pressure: in_valid stays high throughout. The second operation must
    // wait for the first handshake.
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'd1000, 32'd10, 1'b0);
    in_valid  = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd5;
    is_signed = 1'b0;
    wait_result(lat);
    check("bp latency", 32'(lat), 32'd34);
    hq = quotient; hr = remainder; hdbz = div_by_zero; hovf = overflow;
    check("bp quotient",  hq, 32'd100);
    check("bp remainder", hr, 32'd0);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready || quotient !== hq || remainder !== hr
          || div_by_zero !== hdbz || overflow !== hovf)
        stable = 1'b0;
    end
    check("bp held stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp out_valid drop", 32'(out_valid), 32'd0);
    check("bp in_ready rise",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("bp 2nd latency",   32'(lat), 32'd34);
    check("bp 2nd quotient",  quotient, 32'd10);
    check("bp 2nd remainder", remainder, 32'd0);

    // Reset in CALC iteration 10 (cycle T+11)
    issue(32'h12345678, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-rst in_ready",    32'(in_ready),    32'd1);
    check("mid-rst out_valid",   32'(out_valid),   32'd0);
    check("mid-rst quotient",    quotient,         32'd0);
    check("mid-rst remainder",   remainder,        32'd0);
    check("mid-rst div_by_zero", 32'(div_by_zero), 32'd0);
    check("mid-rst overflow",    32'(overflow),    32'd0);
    stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) stable = 1'b0;
    end
    check("mid-rst stays idle", 32'(stable), 32'd1);

    issue(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_result(lat);
    check("post-rst latency",   32'(lat), 32'd34);
    check("post-rst quotient",  quotient, 32'hFFFFFFFF);
    check("post-rst remainder", remainder, 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle restoring integer divider for the ALU datapath: it computes quotient and remainder for signed or unsigned operands, one quotient bit per clock. Each iteration performs one trial subtraction, the same two's-complement add/subtract operation the ALU's add/sub unit provides. The block is the iterative counterpart to the single-cycle arithmetic units and sits beside them behind a valid/ready handshake. Divide-by-zero and signed-overflow results match RISC-V M-extension semantics.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥ 2).

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  WIDTH  two's complement or unsigned, per is_signed.
- divisor  input  WIDTH  two's complement or unsigned, per is_signed.
- is_signed  input  1  1 = signed division, 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  quotient, truncated toward zero.
- remainder  output  WIDTH  remainder; its sign follows the dividend.
- div_by_zero  output  1  divisor was 0.
- overflow  output  1  signed minimum value ÷ −1.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterative loop.
  - FIX: sign correction.
  - DONE: out_valid=1.
- Accept: in_valid && in_ready while in IDLE. Operands and is_signed are captured; later input changes are ignored.
- Special cases are detected at accept. IDLE goes straight to DONE, with no CALC or FIX.
  - divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1.
  - is_signed && dividend==100…0 && divisor==all ones: quotient=dividend, remainder=0, overflow=1.
- Normal path:
  - Take magnitudes: negate a signed operand if its MSB is 1. Set q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend), both only when is_signed.
  - CALC runs exactly WIDTH iterations. Each iteration shifts {rem, quo} left by 1 and trial-subtracts: diff = rem_shifted − |divisor|, evaluated at WIDTH+1 bits.
  - If no borrow: rem=diff and the new quo LSB = 1. Otherwise rem is kept and the LSB = 0.
  - An iteration counter counts 0 to WIDTH−1, and the final count moves the FSM to FIX.
  - FIX: negate quo if q_neg and negate rem if r_neg, then go to DONE. div_by_zero=overflow=0.
- DONE: outputs are held stable while out_valid && !out_ready. When out_valid && out_ready, go to IDLE.
- No bypass: in_ready is 0 in the DONE cycle, even when out_ready=1. A new operation cannot be accepted in the same cycle a result is consumed.
- Outputs are registered; none is combinational from an input.
- Reset (rst_n=0 on a clock edge, in any state, including mid-CALC): the FSM returns to IDLE and the counter clears.
  - Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.

## Timing
- Accept edge is T.
- Normal path: CALC occupies cycles T+1..T+WIDTH, FIX occupies T+WIDTH+1, and out_valid is first high in cycle T+WIDTH+2. Latency is WIDTH+2 cycles (34 at WIDTH=32).
- Special case: out_valid is high in cycle T+1 (latency 1).
- in_ready is low from T+1 until the cycle after the result handshake.
- Minimum issue interval: WIDTH+3 cycles for the normal path and 2 cycles for special cases.
- The quotient/remainder/flag values that are valid together with out_valid remain unchanged until the handshake. After the handshake, outputs keep their last values; consumers must qualify them with out_valid.

## Test plan
- Unsigned 100 ÷ 7 with out_ready=1 → out_valid exactly 34 cycles after accept; quotient=14, remainder=2, both flags 0.
- Signed −7 ÷ 2 (0xFFFFFFF9, 0x00000002) → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also signed 7 ÷ −2 → quotient=0xFFFFFFFD, remainder=1.
- 5 ÷ 0, unsigned and signed → out_valid at T+1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Signed 0x80000000 ÷ 0xFFFFFFFF → out_valid at T+1; quotient=0x80000000, remainder=0, overflow=1. Unsigned with the same operands → 34-cycle path, quotient=0, remainder=0x80000000, overflow=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. Raise out_ready → out_valid drops the next cycle and in_ready=1 the next cycle; in_valid held high the whole time is accepted only then.
- Reset mid-op: assert rst_n=0 for one edge at CALC iteration 10 → next cycle in_ready=1, out_valid=0, and all outputs are 0. A fresh 0xFFFFFFFF ÷ 1 unsigned then gives quotient=0xFFFFFFFF, remainder=0.
